// File: rtl/asic_poc_seq.sv
// asic_poc_seq: always-on power-on-control sequencer that drives the padring poc net.
// Define ASIC_POC_SEQ_STATUS_EN to add the brownout fault counter/sticky status outputs.
module asic_poc_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 16,
   parameter int HOLD        = 64,
   parameter int CW          = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vddio_ok,
   input  logic       vdd_ok,
   input  logic       en,
`ifdef ASIC_POC_SEQ_STATUS_EN
   input  logic       fault_clr,
   output logic [7:0] fault_cnt,
   output logic       fault_sticky,
`endif
   output logic       poc,
   output logic       io_ready,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      OFF = 2'd0,
      DEB = 2'd1,
      HLD = 2'd2,
      RUN = 2'd3
   } state_t;

   localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] HLD_LOAD = CW'(HOLD - 1);

   logic [1:0]             rst_sync_q, rst_sync_d;
   logic                   rst_int;
   logic [SYNC_STAGES-1:0] vddio_sync_q, vddio_sync_d;
   logic [SYNC_STAGES-1:0] vdd_sync_q, vdd_sync_d;
   logic                   pgood;
   logic                   seq_fault;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   poc_q, poc_d;
   logic                   io_ready_q, io_ready_d;

   // Reset asserts everything at once but releases the core only after two clean clk edges.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_sync_q <= 2'b11;
      else       rst_sync_q <= rst_sync_d;
   end

   assign rst_int = rst_sync_q[1];

   always_comb begin
      vddio_sync_d = {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok};
      vdd_sync_d   = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok};
   end

   assign pgood     = vddio_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];
   assign seq_fault = ~pgood | ~en;

   // A fault wins over counter expiry; the counter only decrements while nonzero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         OFF: begin
            if (en && pgood) begin
               state_d = DEB;
               cnt_d   = DEB_LOAD;
            end
         end
         DEB: begin
            if (seq_fault) begin
               state_d = OFF;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = HLD;
               cnt_d   = HLD_LOAD;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         HLD: begin
            if (seq_fault) begin
               state_d = OFF;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         RUN: begin
            if (seq_fault) begin
               state_d = OFF;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = OFF;
            cnt_d   = '0;
         end
      endcase
      poc_d      = (state_d != RUN);
      io_ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         vddio_sync_q <= '0;
         vdd_sync_q   <= '0;
         state_q      <= OFF;
         cnt_q        <= '0;
         poc_q        <= 1'b1;
         io_ready_q   <= 1'b0;
      end else begin
         vddio_sync_q <= vddio_sync_d;
         vdd_sync_q   <= vdd_sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         poc_q        <= poc_d;
         io_ready_q   <= io_ready_d;
      end
   end

   assign poc      = poc_q;
   assign io_ready = io_ready_q;
   assign state    = state_q;

`ifdef ASIC_POC_SEQ_STATUS_EN
   logic [7:0] fault_cnt_q, fault_cnt_d;
   logic       fault_sticky_q, fault_sticky_d;
   logic       pg_drop;

   assign pg_drop = (state_q == RUN) && !pgood;

   // A brownout in the same cycle as fault_clr still records itself as the first fault.
   always_comb begin
      fault_cnt_d    = fault_cnt_q;
      fault_sticky_d = fault_sticky_q;
      if (pg_drop) begin
         fault_sticky_d = 1'b1;
         if (fault_clr)                fault_cnt_d = 8'd1;
         else if (fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
      end else if (fault_clr) begin
         fault_cnt_d    = 8'd0;
         fault_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         fault_cnt_q    <= 8'd0;
         fault_sticky_q <= 1'b0;
      end else begin
         fault_cnt_q    <= fault_cnt_d;
         fault_sticky_q <= fault_sticky_d;
      end
   end

   assign fault_cnt    = fault_cnt_q;
   assign fault_sticky = fault_sticky_q;
`endif

endmodule
